// File: rtl/vga_plot_arbiter.sv
// Single-owner arbiter for the vga_adapter pixel port: grants one renderer at a time,
// registers its pixel stream and drops off-screen pixels. Define VGA_ARB_ROUND_ROBIN_EN for round-robin.

module vga_arb_lane #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           on_screen
);
  assign on_screen = (32'(x) < 32'(X_MAX)) && (32'(y) < 32'(Y_MAX));
endmodule

module vga_plot_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ*X_W-1:0] x_in,
  input  logic [NUM_REQ*Y_W-1:0] y_in,
  input  logic [NUM_REQ*C_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [X_W-1:0]         x_vga,
  output logic [Y_W-1:0]         y_vga,
  output logic [C_W-1:0]         colour_vga,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   clip_err
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [C_W-1:0]       c_q, c_d;
  logic                 we_q, we_d;
  logic                 clip_q, clip_d;
  logic [NUM_REQ-1:0]   lane_on;
  logic [IDX_W-1:0]     win_idx;
  logic                 own_pv, own_done, own_req, own_on;
  logic [X_W-1:0]       own_x;
  logic [Y_W-1:0]       own_y;
  logic [C_W-1:0]       own_c;
`ifdef VGA_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     own_idx;
  int                   j;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    vga_arb_lane #(.X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_lane (
      .x         (x_in[i*X_W +: X_W]),
      .y         (y_in[i*Y_W +: Y_W]),
      .on_screen (lane_on[i])
    );
  end

  // Owner view: gnt_q is one-hot, so OR-ing masked lanes is a clean mux.
  always_comb begin
    own_x = '0;
    own_y = '0;
    own_c = '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
    own_idx = '0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        own_x = x_in[i*X_W +: X_W];
        own_y = y_in[i*Y_W +: Y_W];
        own_c = colour_in[i*C_W +: C_W];
`ifdef VGA_ARB_ROUND_ROBIN_EN
        own_idx = IDX_W'(i);
`endif
      end
    end
  end

  assign own_pv   = |(gnt_q & pix_valid);
  assign own_done = |(gnt_q & done);
  assign own_req  = |(gnt_q & req);
  assign own_on   = |(gnt_q & lane_on);

  always_comb begin
    win_idx = '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
    j = 0;
    // Scan downward so the first hit upward from the pointer wins last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (req[j]) win_idx = IDX_W'(j);
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) win_idx = IDX_W'(i);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    we_d    = 1'b0;
    clip_d  = clip_q;
`ifdef VGA_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = NUM_REQ'(1) << win_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (own_pv) begin
          if (own_on) begin
            we_d = 1'b1;
            x_d  = own_x;
            y_d  = own_y;
            c_d  = own_c;
          end else begin
            clip_d = 1'b1;
          end
        end
        if (own_done || !own_req) begin
          gnt_d   = '0;
          state_d = RELEASE;
`ifdef VGA_ARB_ROUND_ROBIN_EN
          ptr_d = (32'(own_idx) == NUM_REQ - 1) ? '0 : own_idx + 1'b1;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      we_q    <= 1'b0;
      clip_q  <= 1'b0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      we_q    <= we_d;
      clip_q  <= clip_d;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign busy       = |gnt_q;
  assign x_vga      = x_q;
  assign y_vga      = y_q;
  assign colour_vga = c_q;
  assign writeEn    = we_q;
  assign clip_err   = clip_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: expected pixels/grants are queued by the stimulus,
// a negedge monitor pops and compares them; direct checks cover reset, clipping and release.
module tb_vga_plot_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  req = '0, done = '0, pv = '0;
  logic [N*8-1:0] x_in = '0;
  logic [N*7-1:0] y_in = '0;
  logic [N*3-1:0] c_in = '0;
  logic [N-1:0]  gnt;
  logic [7:0]    x_vga;
  logic [6:0]    y_vga;
  logic [2:0]    colour_vga;
  logic          writeEn, busy, clip_err;

  int vectors = 0;
  int errors  = 0;
  logic [17:0] exp_pix[$];
  logic [N-1:0] exp_gnt[$];
  logic [N-1:0] prev_gnt = '0;

  vga_plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .pix_valid(pv),
    .x_in(x_in), .y_in(y_in), .colour_in(c_in), .gnt(gnt),
    .x_vga(x_vga), .y_vga(y_vga), .colour_vga(colour_vga),
    .writeEn(writeEn), .busy(busy), .clip_err(clip_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every plotted pixel and every new grant must match the next queued expectation.
  always @(negedge clk) begin
    if (resetn && writeEn) begin
      vectors++;
      if (exp_pix.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected: got x=%0d y=%0d c=%0d expected none", x_vga, y_vga, colour_vga);
      end else begin
        logic [17:0] e;
        e = exp_pix.pop_front();
        if ({x_vga, y_vga, colour_vga} !== e) begin
          errors++;
          $display("FAIL pix: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   x_vga, y_vga, colour_vga, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (resetn && gnt != '0 && prev_gnt == '0) begin
      vectors++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected: got %b expected none", gnt);
      end else begin
        logic [N-1:0] g;
        g = exp_gnt.pop_front();
        if (gnt !== g) begin
          errors++;
          $display("FAIL gnt_order: got %b expected %b", gnt, g);
        end
      end
    end
    prev_gnt = gnt;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    x_in[i*8 +: 8] = 8'(x);
    y_in[i*7 +: 7] = 7'(y);
    c_in[i*3 +: 3] = 3'(c);
    pv[i] = 1'b1;
  endtask

  task automatic push_pix(input int x, input int y, input int c);
    exp_pix.push_back({8'(x), 7'(y), 3'(c)});
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt == '0 && n < 8) begin
      step();
      n++;
    end
    if (gnt == '0) begin
      vectors++;
      errors++;
      $display("FAIL wait_gnt: got no grant within 8 cycles expected a grant");
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    resetn = 1'b0;
    req = '0; done = '0; pv = '0;
    #3;
    resetn = 1'b1;
    prev_gnt = '0;
  endtask

  logic [N-1:0] order [4];

  initial begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
`else
    order[0] = 3'b001; order[1] = 3'b001; order[2] = 3'b001; order[3] = 3'b001;
`endif
    #2;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(writeEn), 0);
    chk("rst_xyc", 32'({x_vga, y_vga, colour_vga}), 0);
    chk("rst_clip", 32'(clip_err), 0);
    #10 resetn = 1'b1;

    // Single owner streams two pixels then done.
    step();
    req = 3'b010;
    exp_gnt.push_back(3'b010);
    step();
    chk("t1_gnt", 32'(gnt), 32'b010);
    chk("t1_busy", 32'(busy), 1);
    set_pix(1, 10, 20, 6); push_pix(10, 20, 6);
    step();
    set_pix(1, 11, 20, 6); push_pix(11, 20, 6);
    step();
    chk("t1_we2", 32'(writeEn), 1);
    pv = '0; done[1] = 1'b1; req = '0;
    step();
    chk("t1_release_gnt", 32'(gnt), 0);
    chk("t1_release_we", 32'(writeEn), 0);
    done = '0;
    step();
    chk("t1_idle_gnt", 32'(gnt), 0);

    // All requesting: order depends on arbitration mode.
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) exp_gnt.push_back(order[g]);
    for (int g = 0; g < 4; g++) begin
      int o;
      wait_gnt();
      o = (order[g] == 3'b001) ? 0 : (order[g] == 3'b010) ? 1 : 2;
      set_pix(o, 30 + g, 40 + g, g + 1); done[o] = 1'b1;
      push_pix(30 + g, 40 + g, g + 1);
      step();
      chk("t2_release", 32'(gnt), 0);
      pv = '0; done = '0;
      if (g == 3) req = '0;
      step();
    end
    step();
    chk("t2_idle", 32'(gnt), 0);

    // Clipping, non-owner strobe, pixel with done.
    do_reset();
    req = 3'b001;
    exp_gnt.push_back(3'b001);
    wait_gnt();
    set_pix(0, 160, 5, 1);
    step();
    chk("t3_clip_we", 32'(writeEn), 0);
    chk("t3_clip_err", 32'(clip_err), 1);
    chk("t3_clip_hold", 32'({x_vga, y_vga}), 0);
    set_pix(0, 159, 119, 5); push_pix(159, 119, 5);
    step();
    chk("t3_edge_we", 32'(writeEn), 1);
    pv = '0;
    set_pix(2, 1, 1, 7);
    step();
    chk("t4_nonowner_we", 32'(writeEn), 0);
    chk("t4_gnt", 32'(gnt), 32'b001);
    pv = '0;
    set_pix(0, 7, 7, 2); done[0] = 1'b1; push_pix(7, 7, 2);
    step();
    chk("t5_we", 32'(writeEn), 1);
    chk("t5_gnt", 32'(gnt), 0);
    chk("t5_busy", 32'(busy), 0);
    pv = '0; done = '0; req = '0;
    step();
    chk("t5_idle_we", 32'(writeEn), 0);
    chk("t5_clip_sticky", 32'(clip_err), 1);

    // Asynchronous reset mid-stream.
    step();
    req = 3'b010;
    exp_gnt.push_back(3'b010);
    wait_gnt();
    set_pix(1, 50, 50, 3); push_pix(50, 50, 3);
    step();
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_we", 32'(writeEn), 0);
    chk("t6_xyc", 32'({x_vga, y_vga, colour_vga}), 0);
    chk("t6_clip", 32'(clip_err), 0);
    step();
    chk("t6_held_we", 32'(writeEn), 0);
    resetn = 1'b1;
    prev_gnt = '0;
    #1;
    chk("t6_post_gnt", 32'(gnt), 0);
    req = '0; pv = '0;
    step();
    chk("t6_no_gnt", 32'(gnt), 0);
    step();

    chk("pix_queue_empty", 32'(exp_pix.size()), 0);
    chk("gnt_queue_empty", 32'(exp_gnt.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single pixel-write port of `vga_adapter` (x, y, colour, plot) among several renderers (erase, cake, cherry, score), one owner at a time. Each renderer requests the port, streams pixels while granted and signals completion. The arbiter registers the winning stream onto the VGA port and drops out-of-screen pixels. It sits in `game_top` between the render units and `vga_adapter`.

## Interface
- `NUM_REQ`, default 3: number of requesters, 2..4; index 0 = erase, 1 = cake, 2 = cherry.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `C_W`, default 3: colour width.
- `X_MAX`, default 160: columns; pixels with x ≥ X_MAX are dropped.
- `Y_MAX`, default 120: rows; pixels with y ≥ Y_MAX are dropped.

Ports:
- `clk` in 1: system clock (CLOCK_50).
- `resetn` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester port request; level, held until done.
- `done` in NUM_REQ: per-requester one-cycle completion pulse.
- `pix_valid` in NUM_REQ: per-requester pixel strobe.
- `x_in` in NUM_REQ*X_W: packed x buses; requester i at [i*X_W +: X_W].
- `y_in` in NUM_REQ*Y_W: packed y buses.
- `colour_in` in NUM_REQ*C_W: packed colour buses.
- `gnt` out NUM_REQ: one-hot grant, registered.
- `x_vga` out X_W, `y_vga` out Y_W, `colour_vga` out C_W: registered pixel to `vga_adapter`.
- `writeEn` out 1: registered plot strobe.
- `busy` out 1: high while any grant is held.
- `clip_err` out 1: sticky; set when an owner's valid pixel is dropped for being off-screen.

## Operation
- States: IDLE, OWN, RELEASE.
- IDLE: if `req` is nonzero, select a winner (see Configuration), load `gnt` one-hot and enter OWN. Otherwise stay.
- OWN: only the owner's `pix_valid`/x/y/colour are observed; all other requesters' strobes are ignored and not queued.
- Owner's `pix_valid`=1 with x < X_MAX and y < Y_MAX: write x/y/colour to the outputs and pulse `writeEn`.
- Off-screen valid pixel: `writeEn` stays 0, VGA outputs hold, `clip_err` is set.
- Leaving OWN: owner's `done`=1 or owner's `req`=0 moves to RELEASE. A pixel valid in the same cycle as `done` is still written.
- RELEASE: `gnt` = 0 and `busy` = 0 for one cycle, then IDLE. This guarantees a one-cycle gap between owners.
- `done`/`pix_valid` from non-owners, and `done` in IDLE, are ignored.
- `writeEn` is 0 in every cycle without an accepted owner pixel. x/y/colour hold their last values.
- `clip_err` clears only on reset.
- Reset values: state IDLE, `gnt` 0, `busy` 0, `writeEn` 0, `x_vga`/`y_vga`/`colour_vga` 0, `clip_err` 0, round-robin pointer 0.
- Reset asserted mid-stream: all of the above clear immediately (asynchronous). No pixel is emitted after reset asserts.

## Timing
- Request latency: `req` seen high in IDLE at cycle 0 → `gnt`/`busy` high at cycle 1.
- Pixel latency: owner `pix_valid` at cycle k → `writeEn` at k+1, with coordinates from cycle k.
- Throughput: one pixel per cycle, back-to-back.
- Release: `done` at cycle d → `gnt` low at d+1 (RELEASE) → IDLE at d+2 → next `gnt` at d+3 at the earliest.
- Simultaneous requests in IDLE: exactly one grant; losers keep `req` high and wait.

## Configuration
- `VGA_ARB_ROUND_ROBIN_EN` defined:
  - Winner is the first requester with `req`=1 searching upward from the pointer, with wrap-around.
  - On entering RELEASE, the pointer becomes (owner index + 1) mod NUM_REQ.
- `VGA_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the lowest asserted index wins, so erase beats cake beats cherry.
  - No pointer register is built.

## Test plan
- Reset, then req=3'b010, owner streams (10,20,3'b110) and (11,20,3'b110), then done → gnt=3'b010 at cycle 1; writeEn high for two consecutive cycles with those values; gnt=0 one cycle after done.
- req=3'b111 held continuously, each owner sending one pixel plus done:
  - Fixed priority: grant order 0,0,0…
  - Round-robin: grant order 0,1,2,0.
- Owner sends pixel (160,5) and then (159,119) → first dropped (writeEn=0, clip_err=1); second written; clip_err stays 1 until reset.
- Non-owner 2 pulses pix_valid with (1,1) while 0 owns → no writeEn for (1,1); gnt unchanged.
- `pix_valid` and `done` in the same cycle with (7,7) → (7,7) written at the next cycle; then RELEASE, then IDLE.
- resetn low mid-stream → gnt, busy, writeEn and all VGA outputs 0 in the same cycle; after release, no grant until req is resampled in IDLE.
